// File: rtl/bin_bcd_conv.sv
// bin_bcd_conv: sequential binary-to-BCD encoder (shift-and-add-3, one bit
// per clock). Feeds packed BCD digits to the BCD/7-segment decoder blocks.
//
// Handshake: a conversion is accepted on any rising edge where start=1 and
// the block is idle (busy=0). busy is high from the accepting edge until the
// edge that loads the result. done pulses high for exactly one cycle, the
// first idle cycle after the load, and bcd/ovf are valid from that cycle
// until the next completion. start is ignored while busy. bin is only
// sampled on the accepting edge.
module bin_bcd_conv #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf,
    output logic [1:0]          o_dbg_state
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [BIN_W-1:0]   r_bin;      // remaining binary bits, MSB shifts out first
    logic [BCD_W-1:0]   r_scr;      // BCD scratch being built
    logic [BCD_W-1:0]   w_adj;      // scratch after the add-3 correction
    logic [CNT_W-1:0]   r_cnt;      // bits still to shift
    logic               r_sticky;   // any bit lost off the top of the scratch
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;
    logic               r_done;

    logic               w_accept;
    logic               w_shift;
    logic               w_load;
    logic               w_last;
    logic               w_busy;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> SHIFT on start, SHIFT until the last bit, then one LOAD cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_next = ST_SHIFT;
            ST_SHIFT: if (w_last) w_next = ST_LOAD;
            ST_LOAD:              w_next = ST_IDLE;
            default:              w_next = ST_IDLE;
        endcase
    end

    // Output/control decode from the current state.
    always_comb begin
        w_accept    = (r_state == ST_IDLE) && start;
        w_shift     = (r_state == ST_SHIFT);
        w_load      = (r_state == ST_LOAD);
        w_busy      = (r_state != ST_IDLE);
        w_last      = (r_cnt == CNT_W'(1));
        o_dbg_state = r_state;
    end

    // Add-3 correction: every digit of 5 or more is bumped so the shift carries in decimal.
    always_comb begin
        w_adj = r_scr;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_scr[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_scr[4*k +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath: load on accept, then one corrected shift per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin    <= '0;
            r_scr    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (w_accept) begin
            r_bin    <= bin;
            r_scr    <= '0;
            r_cnt    <= CNT_W'(BIN_W);
            r_sticky <= 1'b0;
        end else if (w_shift) begin
            // The digit shifted off the top is worth exactly 10^DIGITS, so the
            // scratch keeps the low digits and the lost carry flags overflow.
            r_scr    <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
            r_bin    <= r_bin << 1;
            r_cnt    <= r_cnt - CNT_W'(1);
            r_sticky <= r_sticky | w_adj[BCD_W-1];
        end
    end

    // Result registers: updated only in LOAD, done pulses for the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd  <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_load;
            if (w_load) begin
                r_bcd <= r_scr;
                r_ovf <= r_sticky;
            end
        end
    end

    assign busy = w_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_bin_bcd_conv.sv
// Self-checking bench for bin_bcd_conv. Three instances share clock, reset,
// start and bin: the default 8-bit/3-digit build, an 8-bit/2-digit build that
// exercises overflow wrap, and a 1-bit/1-digit build for the minimal width.
module tb_bin_bcd_conv;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  bin_s = 8'd0;

    logic        busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;
    logic [1:0]  st_a;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic [1:0]  st_b;
    logic        busy_c, done_c, ovf_c;
    logic [3:0]  bcd_c;
    logic [1:0]  st_c;

    int n_vec = 0;
    int n_err = 0;

    // Results captured by run_conv.
    logic [11:0] got_a;
    logic        gov_a;
    logic [7:0]  got_b;
    logic        gov_b;
    logic [3:0]  got_c;
    int          lat_a, lat_b, lat_c;
    bit          busy_ok, hold_ok;

    always #5 clk = ~clk;

    bin_bcd_conv #(.BIN_W(8), .DIGITS(3)) dut_a (
        .clk(clk), .rst(rst), .start(start), .bin(bin_s),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a), .o_dbg_state(st_a)
    );

    bin_bcd_conv #(.BIN_W(8), .DIGITS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .bin(bin_s),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b), .o_dbg_state(st_b)
    );

    bin_bcd_conv #(.BIN_W(1), .DIGITS(1)) dut_c (
        .clk(clk), .rst(rst), .start(start), .bin(bin_s[0:0]),
        .busy(busy_c), .done(done_c), .bcd(bcd_c), .ovf(ovf_c), .o_dbg_state(st_c)
    );

    // Reference: decimal digits of v by division, low d digits packed.
    function automatic logic [11:0] ref_bcd(input int v, input int d);
        logic [11:0] r;
        int p;
        r = '0;
        p = v;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(p % 10);
            p = p / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int v, input int d);
        int lim;
        lim = 1;
        for (int k = 0; k < d; k++) lim = lim * 10;
        return (v >= lim);
    endfunction

    // Starts a conversion of v (called at posedge+1), scrambles bin after
    // acceptance, and returns at posedge+1 of dut_a's done cycle.
    task automatic run_conv(input int v);
        logic [11:0] prev;
        prev    = bcd_a;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        lat_a   = 0;
        lat_b   = 0;
        lat_c   = 0;
        start   = 1'b1;
        bin_s   = 8'(v);
        @(posedge clk); #1;
        start = 1'b0;
        bin_s = 8'($urandom);
        if (!busy_a) busy_ok = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done_c && lat_c == 0) begin lat_c = n; got_c = bcd_c; end
            if (done_b && lat_b == 0) begin lat_b = n; got_b = bcd_b; gov_b = ovf_b; end
            if (done_a) begin lat_a = n; got_a = bcd_a; gov_a = ovf_a; break; end
            if (!busy_a) busy_ok = 1'b0;
            if (bcd_a !== prev) hold_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done_a); end
        n_vec++; if (bcd_a !== 12'h000) begin n_err++; $display("FAIL reset_bcd: got %h expected 000", bcd_a); end
        n_vec++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf_a); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if ({busy_a, done_a, bcd_a} !== 14'd0) begin n_err++; $display("FAIL idle_before_start: got busy=%b done=%b bcd=%h expected 0/0/000", busy_a, done_a, bcd_a); end
    endtask

    task automatic test_zero;
        run_conv(0);
        n_vec++; if (lat_a != 9) begin n_err++; $display("FAIL zero_latency: got %0d expected 9", lat_a); end
        n_vec++; if (got_a !== 12'h000 || gov_a !== 1'b0) begin n_err++; $display("FAIL zero_value: got %h/%b expected 000/0", got_a, gov_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL zero_busy_done: got %b expected 0", busy_a); end
        @(posedge clk); #1;
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b expected 0", done_a); end
        n_vec++; if (bcd_a !== 12'h000) begin n_err++; $display("FAIL zero_hold: got %h expected 000", bcd_a); end
    endtask

    task automatic test_directed;
        int vals[14] = '{255, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 99, 100, 200};
        logic [11:0] e;
        for (int i = 0; i < 14; i++) begin
            run_conv(vals[i]);
            e = ref_bcd(vals[i], 3);
            n_vec++; if (got_a !== e || lat_a != 9) begin n_err++; $display("FAIL directed_%0d: got %h lat %0d expected %h lat 9", vals[i], got_a, lat_a, e); end
            for (int k = 0; k < 3; k++) begin
                n_vec++; if (got_a[4*k +: 4] > 4'd9) begin n_err++; $display("FAIL digit_range_%0d_%0d: got %h expected 0..9", vals[i], k, got_a[4*k +: 4]); end
            end
        end
    endtask

    task automatic test_exhaustive;
        logic [11:0] ea, eb;
        for (int v = 0; v < 256; v++) begin
            run_conv(v);
            ea = ref_bcd(v, 3);
            eb = ref_bcd(v, 2);
            n_vec++; if (got_a !== ea || gov_a !== ref_ovf(v, 3) || lat_a != 9) begin n_err++; $display("FAIL exh3_%0d: got %h/%b lat %0d expected %h/%b lat 9", v, got_a, gov_a, lat_a, ea, ref_ovf(v, 3)); end
            n_vec++; if (got_b !== eb[7:0] || gov_b !== ref_ovf(v, 2) || lat_b != 9) begin n_err++; $display("FAIL exh2_%0d: got %h/%b lat %0d expected %h/%b lat 9", v, got_b, gov_b, lat_b, eb[7:0], ref_ovf(v, 2)); end
            n_vec++; if (got_c !== 4'(v % 2) || lat_c != 2) begin n_err++; $display("FAIL exh1_%0d: got %h lat %0d expected %h lat 2", v, got_c, lat_c, 4'(v % 2)); end
            n_vec++; if (!busy_ok || !hold_ok) begin n_err++; $display("FAIL exh_handshake_%0d: got busy_ok=%b hold_ok=%b expected 1/1", v, busy_ok, hold_ok); end
        end
    endtask

    task automatic test_random;
        int v;
        logic [11:0] ea, eb;
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, 255);
            run_conv(v);
            ea = ref_bcd(v, 3);
            eb = ref_bcd(v, 2);
            n_vec++; if (got_a !== ea || gov_a !== 1'b0) begin n_err++; $display("FAIL rand3_%0d: got %h/%b expected %h/0", v, got_a, gov_a, ea); end
            n_vec++; if (got_b !== eb[7:0] || gov_b !== ref_ovf(v, 2)) begin n_err++; $display("FAIL rand2_%0d: got %h/%b expected %h/%b", v, got_b, gov_b, eb[7:0], ref_ovf(v, 2)); end
        end
    endtask

    task automatic test_digits2;
        run_conv(100);
        n_vec++; if (got_b !== 8'h00 || gov_b !== 1'b1) begin n_err++; $display("FAIL d2_100: got %h/%b expected 00/1", got_b, gov_b); end
        run_conv(99);
        n_vec++; if (got_b !== 8'h99 || gov_b !== 1'b0) begin n_err++; $display("FAIL d2_99: got %h/%b expected 99/0", got_b, gov_b); end
        run_conv(255);
        n_vec++; if (got_b !== 8'h55 || gov_b !== 1'b1) begin n_err++; $display("FAIL d2_255: got %h/%b expected 55/1", got_b, gov_b); end
    endtask

    task automatic test_back_to_back;
        run_conv(128);
        n_vec++; if (got_a !== 12'h128) begin n_err++; $display("FAIL b2b_first: got %h expected 128", got_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL b2b_busy_gap: got %b expected 0", busy_a); end
        // start is raised right here, inside the done cycle
        run_conv(42);
        n_vec++; if (got_a !== 12'h042 || lat_a != 9) begin n_err++; $display("FAIL b2b_second: got %h lat %0d expected 042 lat 9", got_a, lat_a); end
        n_vec++; if (!busy_ok || !hold_ok) begin n_err++; $display("FAIL b2b_busy_hold: got busy_ok=%b hold_ok=%b expected 1/1", busy_ok, hold_ok); end
    endtask

    task automatic test_start_ignored;
        int n_done, first_n;
        bit busy_drop;
        logic [11:0] got;
        n_done    = 0;
        first_n   = 0;
        busy_drop = 1'b0;
        got       = '0;
        start = 1'b1;
        bin_s = 8'd5;
        for (int n = 1; n <= 25; n++) begin
            @(posedge clk); #1;
            if (n == 2) begin start = 1'b1; bin_s = 8'd77; end
            else begin start = 1'b0; bin_s = 8'($urandom); end
            if (done_a) begin
                n_done++;
                if (first_n == 0) begin first_n = n; got = bcd_a; end
            end else if (n_done == 0 && n <= 9 && !busy_a) begin
                busy_drop = 1'b1;
            end
        end
        start = 1'b0;
        n_vec++; if (n_done != 1) begin n_err++; $display("FAIL ignore_done_count: got %0d expected 1", n_done); end
        n_vec++; if (got !== 12'h005 || first_n != 10) begin n_err++; $display("FAIL ignore_value: got %h at %0d expected 005 at 10", got, first_n); end
        n_vec++; if (busy_drop) begin n_err++; $display("FAIL ignore_busy_drop: got 1 expected 0"); end
    endtask

    task automatic test_reset_abort;
        int n_done;
        n_done = 0;
        start = 1'b1;
        bin_s = 8'd250;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_err++; $display("FAIL abort_flags: got busy=%b done=%b expected 0/0", busy_a, done_a); end
        n_vec++; if (bcd_a !== 12'h000 || ovf_a !== 1'b0) begin n_err++; $display("FAIL abort_bcd: got %h/%b expected 000/0", bcd_a, ovf_a); end
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (done_a) n_done++;
        end
        n_vec++; if (n_done != 0) begin n_err++; $display("FAIL abort_no_done: got %0d expected 0", n_done); end
        run_conv(250);
        n_vec++; if (got_a !== 12'h250 || lat_a != 9) begin n_err++; $display("FAIL abort_restart: got %h lat %0d expected 250 lat 9", got_a, lat_a); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_directed();
        test_digits2();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
        test_random();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
